mem_access: RTL and testbench
=============================

# mem_access

Memory-access pipeline stage that consumes the execute stage's output bundle (IR, ALU result, branch comparison, PC, store data) over the v/r handshake. It performs RV32I loads and stores against a variable-latency data-memory port, resolves branch redirects, and presents a writeback bundle downstream. It also drives the MEM forwarding pair (FM/AM) back into execute.

## Interface
- No parameters; all datapaths are fixed at 32 bits (RV32I).

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- v_in  in  1  execute bundle valid
- r_out  out  1  ready to accept execute bundle
- IR  in  32  instruction from execute
- ALU  in  32  ALU result; effective address for load/store, target for branch
- COMP  in  1  branch-condition result
- PC  in  32  instruction PC
- B  in  32  store data (rs2)
- v_out  out  1  writeback bundle valid
- r_in  in  1  writeback ready
- IR_out  out  32  held instruction
- RES_out  out  32  writeback value
- err  out  1  misaligned access flag, qualified by v_out
- br_taken  out  1  branch redirect strobe
- br_target  out  32  redirect address
- FM  out  32  forwarded value (equals RES_out)
- AM  out  5  forwarded register address; 0 means none
- dm_req  out  1  data-memory request
- dm_we  out  1  1 = write
- dm_addr  out  32  word address, bits [1:0] = 0
- dm_be  out  4  byte enables
- dm_wdata  out  32  write data
- dm_ack  in  1  request completion; for reads, dm_rdata is valid in the same cycle
- dm_rdata  in  32  read data

## Operation
- States:
  - IDLE: empty.
  - BUSY: memory request outstanding.
  - FULL: result held.
- r_out = (IDLE) | (FULL & r_in). This is combinational. v_out = FULL.
- Accept on v_in & r_out: latch IR, ALU, COMP, PC, B. The opcode IR[6:0] selects the next state.
- Branch (1100011): go to FULL. RES = 0, no writeback. br_target = latched ALU.
- JAL (1101111) and JALR (1100111): go to FULL with RES = PC+4.
- LUI, AUIPC, OP, OP-IMM: go to FULL with RES = ALU.
- Load (0000011) or store (0100011):
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Misaligned: go to FULL, err=1, RES=0, no memory request, no writeback.
  - Aligned: go to BUSY.
- BUSY:
  - dm_req=1, with dm_addr = {ALU[31:2],2'b00}.
  - dm_we, dm_be, and dm_wdata stay stable until dm_ack.
- Store byte enables and data by funct3:
  - SB: be = 1<<addr[1:0], wdata = {4{B[7:0]}}.
  - SH: be = 4'b0011<<addr[1:0], wdata = {2{B[15:0]}}.
  - SW: be = 4'hF, wdata = B.
- Loads: be = 4'hF. On dm_ack, extract the lane at addr[1:0]:
  - LB / LH: sign-extend.
  - LBU / LHU: zero-extend.
  - LW: whole word.
- dm_ack in BUSY moves to FULL. dm_ack outside BUSY is ignored.
- FULL & r_in: go to IDLE, or accept a new bundle in the same edge.
- AM = IR_out[11:7] when FULL and the instruction writes rd (not branch, not store, err=0); otherwise AM = 0.
- br_taken = v_out & r_in & branch & COMP_latched & ~err. It is a single-cycle strobe on handoff.
- Unknown opcodes are treated as writeback of ALU.

## Timing
- Reset values:
  - State IDLE, so r_out=1.
  - v_out=0, dm_req=0, err=0, br_taken=0, AM=0.
  - IR_out, RES_out, dm_addr, dm_be, dm_wdata all 0.
- Non-memory latency: accepted at edge n, v_out=1 from edge n.
- Memory latency:
  - Accepted at edge n; dm_req=1 after edge n.
  - dm_ack sampled high at edge n+k (k≥1) gives v_out=1 after edge n+k.
  - Zero-wait memory therefore yields 2 cycles.
- While BUSY: r_out=0, AM=0. Execute stalls on its own waitlist.
- Back-to-back: FULL with r_in=1 and v_in=1 drains and accepts in one edge with no bubble.
- Backpressure: FULL with r_in=0 holds all outputs (incl. FM/AM) unchanged, and r_out=0.
- rst mid-BUSY: the request is dropped and dm_req=0 after that edge. The memory must tolerate an abandoned request. The latched bundle is discarded.
- rst has priority over accept and over dm_ack in the same cycle.

## Test plan
- Accept ADDI x5 with ALU=0x1234, r_in=1 -> v_out=1 next cycle, RES_out=0x1234, AM=5, FM=0x1234, r_out=1 during drain.
- LB x7 at ALU=0x103, dm_rdata=0x80FFFFFF, dm_ack after 3 BUSY cycles:
  - dm_req held 3 cycles with dm_addr=0x100.
  - Then RES_out=0xFFFFFF80, AM=7.
  - Repeat as LBU -> 0x00000080.
- SH at ALU=0x202, B=0xAAAABEEF -> dm_we=1, dm_be=4'b1100, dm_wdata=0xBEEFBEEF, AM=0 when FULL.
- LW at ALU=0x101 -> no dm_req, v_out next cycle with err=1, RES=0, AM=0.
- BEQ with COMP=1, ALU=0x40, r_in held 0 for 2 cycles then 1:
  - br_taken low while stalled.
  - One-cycle pulse on handoff, br_target=0x40.
- Stream of 4 ALU ops with r_in=1 -> one result per cycle, no bubble.
- rst during BUSY -> dm_req=0, v_out=0, r_out=1 next cycle.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage for an RV32I core.
//
// Takes the execute bundle (IR, ALU result, branch condition, PC and store
// data) over a valid/ready handshake. It then does one of three things:
//   - performs a load or store on a variable-latency data-memory port,
//   - resolves a branch redirect,
//   - passes an ALU/link result straight through.
// The result is presented downstream as a writeback bundle. The MEM
// forwarding pair (FM/AM) is driven back into execute.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   v_in, r_out     execute-side handshake (r_out is combinational)
//   IR, ALU, COMP,  execute bundle: instruction, ALU result / effective
//   PC, B           address / branch target, branch condition, PC, rs2 data
//   v_out, r_in     writeback-side handshake
//   IR_out, RES_out held instruction and writeback value
//   err             misaligned load/store flag, qualified by v_out
//   br_taken        one-cycle redirect strobe on branch handoff
//   br_target       redirect address
//   FM, AM          forwarded value and register (AM = 0 means none)
//   dm_*            data-memory request port; dm_ack completes a request and
//                   carries read data in the same cycle
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_in,
  output logic        r_out,
  input  logic [31:0] IR,
  input  logic [31:0] ALU,
  input  logic        COMP,
  input  logic [31:0] PC,
  input  logic [31:0] B,
  output logic        v_out,
  input  logic        r_in,
  output logic [31:0] IR_out,
  output logic [31:0] RES_out,
  output logic        err,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic [31:0] FM,
  output logic [4:0]  AM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t state;
  state_t next_state;

  logic [31:0] ir_q;
  logic [31:0] alu_q;
  logic        comp_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        err_q;

  logic        accept;

  // Decode of the incoming bundle, used at the accept edge.
  logic [6:0]  in_op;
  logic [2:0]  in_f3;
  logic        in_is_mem;
  logic        in_misaligned;
  logic [31:0] in_res;
  state_t      in_target;

  // Decode of the latched bundle.
  logic [6:0]  q_op;
  logic [2:0]  q_f3;
  logic        q_is_load;
  logic        q_is_store;
  logic        q_is_branch;
  logic        q_writes_rd;

  logic [31:0] load_lane;
  logic [31:0] load_val;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  assign accept = v_in & r_out;

  // Classify the incoming instruction.
  // A misaligned memory access goes straight to FULL with err set and never
  // touches the memory port. funct3[1] marks a word-sized access.
  always_comb begin
    in_op         = IR[6:0];
    in_f3         = IR[14:12];
    in_is_mem     = (in_op == OP_LOAD) || (in_op == OP_STORE);
    in_misaligned = ((in_f3[1:0] == 2'b01) && ALU[0]) ||
                    (in_f3[1] && (ALU[1:0] != 2'b00));
    in_target     = (in_is_mem && !in_misaligned) ? BUSY : FULL;
    case (in_op)
      OP_BRANCH:         in_res = 32'd0;
      OP_JAL, OP_JALR:   in_res = PC + 32'd4;
      OP_LOAD, OP_STORE: in_res = 32'd0;
      default:           in_res = ALU;
    endcase
  end

  // Classify the held instruction.
  always_comb begin
    q_op        = ir_q[6:0];
    q_f3        = ir_q[14:12];
    q_is_load   = (q_op == OP_LOAD);
    q_is_store  = (q_op == OP_STORE);
    q_is_branch = (q_op == OP_BRANCH);
    q_writes_rd = !q_is_branch && !q_is_store;
  end

  // Load data path: shift the addressed lane down to bit 0, then extend it
  // according to the access size and signedness.
  always_comb begin
    load_lane = dm_rdata >> {alu_q[1:0], 3'b000};
    case (q_f3)
      3'b000:  load_val = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b001:  load_val = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b100:  load_val = {24'd0, load_lane[7:0]};
      3'b101:  load_val = {16'd0, load_lane[15:0]};
      default: load_val = load_lane;
    endcase
  end

  // Store path: byte enables follow the address offset, and the data is
  // replicated across all lanes so the enabled lanes always hold it.
  // Loads request the whole word.
  always_comb begin
    store_be    = 4'hF;
    store_wdata = b_q;
    if (q_is_store) begin
      case (q_f3[1:0])
        2'b00: begin
          store_be    = 4'b0001 << alu_q[1:0];
          store_wdata = {4{b_q[7:0]}};
        end
        2'b01: begin
          store_be    = 4'b0011 << alu_q[1:0];
          store_wdata = {2{b_q[15:0]}};
        end
        default: begin
          store_be    = 4'hF;
          store_wdata = b_q;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  // When FULL drains with a new bundle waiting, the stage drains and
  // accepts on the same edge, so no bubble is inserted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (v_in) next_state = in_target;
      end
      BUSY: begin
        if (dm_ack) next_state = FULL;
      end
      FULL: begin
        if (r_in) next_state = v_in ? in_target : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic.
  // The memory port is only driven while BUSY. Its fields come straight
  // from latched registers, so they stay stable until dm_ack arrives.
  always_comb begin
    r_out     = (state == IDLE) || ((state == FULL) && r_in);
    v_out     = (state == FULL);
    dm_req    = (state == BUSY);
    dm_we     = (state == BUSY) && q_is_store;
    dm_addr   = (state == BUSY) ? {alu_q[31:2], 2'b00} : 32'd0;
    dm_be     = (state == BUSY) ? store_be : 4'd0;
    dm_wdata  = (state == BUSY) ? (q_is_store ? store_wdata : 32'd0) : 32'd0;
    err       = (state == FULL) && err_q;
    br_taken  = (state == FULL) && r_in && q_is_branch && comp_q && !err_q;
    br_target = alu_q;
    AM        = ((state == FULL) && q_writes_rd && !err_q) ? ir_q[11:7] : 5'd0;
    IR_out    = ir_q;
    RES_out   = res_q;
    FM        = res_q;
  end

  // Bundle registers.
  // Reset wins over both accept and dm_ack. A request abandoned by reset
  // is simply forgotten. On a memory completion, loads capture the extracted
  // lane; stores write nothing back.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q   <= 32'd0;
      alu_q  <= 32'd0;
      comp_q <= 1'b0;
      b_q    <= 32'd0;
      res_q  <= 32'd0;
      err_q  <= 1'b0;
    end else if (accept) begin
      ir_q   <= IR;
      alu_q  <= ALU;
      comp_q <= COMP;
      b_q    <= B;
      res_q  <= in_res;
      err_q  <= in_is_mem && in_misaligned;
    end else if ((state == BUSY) && dm_ack) begin
      res_q  <= q_is_load ? load_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access.
//
// The stimulus process pushes expected writeback bundles into a queue. A
// monitor pops and compares them on every downstream handoff. A small
// memory responder acknowledges requests after a programmable wait and
// records what the DUT drove on the port.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_in;
  logic        r_out;
  logic [31:0] ir_in;
  logic [31:0] alu_in;
  logic        comp_in;
  logic [31:0] pc_in;
  logic [31:0] b_in;
  logic        v_out;
  logic        r_in;
  logic [31:0] ir_out;
  logic [31:0] res_out;
  logic        err;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] fm;
  logic [4:0]  am;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] res;
    logic        err;
    logic [4:0]  am;
    logic        br;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];

  int          mem_wait = 1;
  int          req_cycles = 0;
  logic        last_we;
  logic [31:0] last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .v_in(v_in), .r_out(r_out),
    .IR(ir_in), .ALU(alu_in), .COMP(comp_in), .PC(pc_in), .B(b_in),
    .v_out(v_out), .r_in(r_in), .IR_out(ir_out), .RES_out(res_out),
    .err(err), .br_taken(br_taken), .br_target(br_target),
    .FM(fm), .AM(am),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bundle and hold it until the DUT accepts it.
  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] alu,
                               input logic [31:0] pc, input logic [31:0] b,
                               input logic comp, input bit push,
                               input exp_t e);
    int waited;
    if (push) exp_q.push_back(e);
    ir_in   = ir;
    alu_in  = alu;
    pc_in   = pc;
    b_in    = b;
    comp_in = comp;
    v_in    = 1'b1;
    #1;
    waited = 0;
    while (!r_out && waited < 100) begin
      tick();
      waited++;
    end
    if (!r_out) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: r_out stayed 0 for ir 0x%08h", ir);
    end
    @(posedge clk);
    #1;
    v_in = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      tick();
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: %0d results never handed off", name, exp_q.size());
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ir, input logic [31:0] res,
                              input logic e, input logic [4:0] a,
                              input logic br, input logic [31:0] tgt);
    exp_t x;
    x.ir = ir; x.res = res; x.err = e; x.am = a; x.br = br; x.tgt = tgt;
    return x;
  endfunction

  // Monitor: every downstream handoff must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && v_out && r_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_handoff: ir 0x%08h res 0x%08h", ir_out, res_out);
        end else begin
          e = exp_q.pop_front();
          checkOutput("mon_ir", ir_out, e.ir);
          checkOutput("mon_res", res_out, e.res);
          checkOutput("mon_fm", fm, e.res);
          checkOutput("mon_err", {31'd0, err}, {31'd0, e.err});
          checkOutput("mon_am", {27'd0, am}, {27'd0, e.am});
          checkOutput("mon_br_taken", {31'd0, br_taken}, {31'd0, e.br});
          if (e.br) checkOutput("mon_br_target", br_target, e.tgt);
        end
      end
    end
  end

  // Memory responder: acknowledges after mem_wait request cycles and checks
  // that the request fields hold steady while it is outstanding.
  initial begin
    int cnt;
    cnt    = 0;
    dm_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (dm_req) begin
        if (req_cycles > 0) begin
          checkOutput("req_addr_stable", dm_addr, last_addr);
          checkOutput("req_be_stable", {28'd0, dm_be}, {28'd0, last_be});
          checkOutput("req_wdata_stable", dm_wdata, last_wdata);
        end
        req_cycles++;
        last_we    = dm_we;
        last_addr  = dm_addr;
        last_be    = dm_be;
        last_wdata = dm_wdata;
        cnt++;
        dm_ack = (cnt >= mem_wait);
      end else begin
        cnt    = 0;
        dm_ack = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t none;
    none = mk(32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    rst = 1'b1; v_in = 1'b0; r_in = 1'b1;
    ir_in = 32'd0; alu_in = 32'd0; comp_in = 1'b0; pc_in = 32'd0; b_in = 32'd0;
    dm_rdata = 32'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    checkOutput("rst_r_out", {31'd0, r_out}, 32'd1);
    checkOutput("rst_v_out", {31'd0, v_out}, 32'd0);
    checkOutput("rst_dm_req", {31'd0, dm_req}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_br_taken", {31'd0, br_taken}, 32'd0);
    checkOutput("rst_am", {27'd0, am}, 32'd0);
    checkOutput("rst_ir_out", ir_out, 32'd0);
    checkOutput("rst_res_out", res_out, 32'd0);
    checkOutput("rst_dm_addr", dm_addr, 32'd0);
    checkOutput("rst_dm_be", {28'd0, dm_be}, 32'd0);
    checkOutput("rst_dm_wdata", dm_wdata, 32'd0);

    // ADDI x5: result visible right after the accept edge.
    applyStimulus(32'h00000293, 32'h00001234, 32'h0, 32'h0, 1'b0, 1'b1,
                  mk(32'h00000293, 32'h00001234, 1'b0, 5'd5, 1'b0, 32'd0));
    checkOutput("addi_v_out", {31'd0, v_out}, 32'd1);
    checkOutput("addi_r_out", {31'd0, r_out}, 32'd1);
    checkOutput("addi_am", {27'd0, am}, 32'd5);
    waitDrain("addi_drain");

    // LB x7 at 0x103 with 3 request cycles.
    mem_wait = 3; req_cycles = 0; dm_rdata = 32'h80FFFFFF;
    applyStimulus(32'h00000383, 32'h00000103, 32'h0, 32'h0, 1'b0, 1'b1,
                  mk(32'h00000383, 32'hFFFFFF80, 1'b0, 5'd7, 1'b0, 32'd0));
    checkOutput("lb_dm_req", {31'd0, dm_req}, 32'd1);
    checkOutput("lb_r_out", {31'd0, r_out}, 32'd0);
    checkOutput("lb_busy_am", {27'd0, am}, 32'd0);
    checkOutput("lb_dm_addr", dm_addr, 32'h00000100);
    waitDrain("lb_drain");
    checkOutput("lb_req_cycles", req_cycles, 32'd3);
    checkOutput("lb_dm_be", {28'd0, last_be}, 32'hF);
    checkOutput("lb_dm_we", {31'd0, last_we}, 32'd0);

    // LBU x7, same address and data.
    req_cycles = 0;
    applyStimulus(32'h00004383, 32'h00000103, 32'h0, 32'h0, 1'b0, 1'b1,
                  mk(32'h00004383, 32'h00000080, 1'b0, 5'd7, 1'b0, 32'd0));
    waitDrain("lbu_drain");
    checkOutput("lbu_req_cycles", req_cycles, 32'd3);

    // SH at 0x202.
    mem_wait = 1; req_cycles = 0;
    applyStimulus(32'h00001023, 32'h00000202, 32'h0, 32'hAAAABEEF, 1'b0, 1'b1,
                  mk(32'h00001023, 32'h00000000, 1'b0, 5'd0, 1'b0, 32'd0));
    waitDrain("sh_drain");
    checkOutput("sh_req_cycles", req_cycles, 32'd1);
    checkOutput("sh_dm_we", {31'd0, last_we}, 32'd1);
    checkOutput("sh_dm_addr", last_addr, 32'h00000200);
    checkOutput("sh_dm_be", {28'd0, last_be}, 32'hC);
    checkOutput("sh_dm_wdata", last_wdata, 32'hBEEFBEEF);

    // Misaligned LW x3 at 0x101: no memory traffic, err on the next cycle.
    req_cycles = 0;
    applyStimulus(32'h00002183, 32'h00000101, 32'h0, 32'h0, 1'b0, 1'b1,
                  mk(32'h00002183, 32'h00000000, 1'b1, 5'd0, 1'b0, 32'd0));
    checkOutput("lw_mis_v_out", {31'd0, v_out}, 32'd1);
    checkOutput("lw_mis_dm_req", {31'd0, dm_req}, 32'd0);
    checkOutput("lw_mis_err", {31'd0, err}, 32'd1);
    waitDrain("lw_mis_drain");
    checkOutput("lw_mis_req_cycles", req_cycles, 32'd0);

    // BEQ taken to 0x40 with downstream stalled for 2 cycles.
    r_in = 1'b0;
    applyStimulus(32'h00000063, 32'h00000040, 32'h0, 32'h0, 1'b1, 1'b1,
                  mk(32'h00000063, 32'h00000000, 1'b0, 5'd0, 1'b1, 32'h00000040));
    checkOutput("beq_stall0_br", {31'd0, br_taken}, 32'd0);
    checkOutput("beq_stall0_r_out", {31'd0, r_out}, 32'd0);
    tick();
    checkOutput("beq_stall1_br", {31'd0, br_taken}, 32'd0);
    checkOutput("beq_stall1_v_out", {31'd0, v_out}, 32'd1);
    r_in = 1'b1;
    #1;
    checkOutput("beq_pulse", {31'd0, br_taken}, 32'd1);
    checkOutput("beq_target", br_target, 32'h00000040);
    waitDrain("beq_drain");
    tick();
    checkOutput("beq_pulse_end", {31'd0, br_taken}, 32'd0);

    // Back-to-back stream: ADDI, LUI, ADD, AUIPC, then JAL (link = PC+4).
    applyStimulus(32'h00000093, 32'h00000001, 32'h0, 32'h0, 1'b0, 1'b1,
                  mk(32'h00000093, 32'h00000001, 1'b0, 5'd1, 1'b0, 32'd0));
    applyStimulus(32'h00000137, 32'hABCDE000, 32'h0, 32'h0, 1'b0, 1'b1,
                  mk(32'h00000137, 32'hABCDE000, 1'b0, 5'd2, 1'b0, 32'd0));
    checkOutput("stream_v_out1", {31'd0, v_out}, 32'd1);
    applyStimulus(32'h000001B3, 32'h00000055, 32'h0, 32'h0, 1'b0, 1'b1,
                  mk(32'h000001B3, 32'h00000055, 1'b0, 5'd3, 1'b0, 32'd0));
    checkOutput("stream_v_out2", {31'd0, v_out}, 32'd1);
    applyStimulus(32'h00000217, 32'h00002000, 32'h0, 32'h0, 1'b0, 1'b1,
                  mk(32'h00000217, 32'h00002000, 1'b0, 5'd4, 1'b0, 32'd0));
    checkOutput("stream_v_out3", {31'd0, v_out}, 32'd1);
    applyStimulus(32'h000002EF, 32'h00000000, 32'h00001000, 32'h0, 1'b0, 1'b1,
                  mk(32'h000002EF, 32'h00001004, 1'b0, 5'd5, 1'b0, 32'd0));
    checkOutput("stream_v_out4", {31'd0, v_out}, 32'd1);
    waitDrain("stream_drain");

    // Reset while a load is outstanding.
    mem_wait = 1000;
    applyStimulus(32'h00002183, 32'h00000300, 32'h0, 32'h0, 1'b0, 1'b0, none);
    tick();
    checkOutput("rstbusy_dm_req_before", {31'd0, dm_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rstbusy_dm_req", {31'd0, dm_req}, 32'd0);
    checkOutput("rstbusy_v_out", {31'd0, v_out}, 32'd0);
    checkOutput("rstbusy_r_out", {31'd0, r_out}, 32'd1);
    rst = 1'b0;
    mem_wait = 1;
    tick();
    tick();
    checkOutput("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
